// File: rtl/pwm_ramp_pkg.sv
// Shared types and widths for the PWM duty-cycle ramp controller.
package pwm_ramp_pkg;

    localparam int DUTY_W = 8;
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_ramp_tick.sv
// Reloadable prescaler: counts down from div_i, pulses tick_o at zero and reloads.
module pwm_ramp_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = div_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Slews a PWM duty cycle toward a target in step_size increments per prescaler tick.
// Define PWM_RAMP_DOWN_EN to also slew decreases; otherwise decreases are applied at once.
module pwm_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ramp_en,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic [STEP_W-1:0] step_size,
    input  logic [DIV_W-1:0]  tick_div,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d, duty_nxt;
    logic              busy_q, done_q, done_d;
    logic              presc_clr, presc_load, presc_en, tick;
    logic [DUTY_W:0]   step9;

    // Arithmetic is done one bit wider so neither direction can wrap before clamping.
    function automatic logic [DUTY_W-1:0] sat_add(input logic [DUTY_W-1:0] d,
                                                  input logic [DUTY_W:0]   s,
                                                  input logic [DUTY_W-1:0] t);
        logic [DUTY_W:0] sum;
        sum = {1'b0, d} + s;
        return (sum > {1'b0, t}) ? t : sum[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] sat_sub(input logic [DUTY_W-1:0] d,
                                                  input logic [DUTY_W:0]   s,
                                                  input logic [DUTY_W-1:0] t);
        logic [DUTY_W:0] diff;
        diff = {1'b0, d} - s;
        return (diff[DUTY_W] || (diff[DUTY_W-1:0] < t)) ? t : diff[DUTY_W-1:0];
    endfunction

    assign step9 = (step_size == '0) ? {{DUTY_W{1'b0}}, 1'b1}
                                     : {{(DUTY_W+1-STEP_W){1'b0}}, step_size};

    pwm_ramp_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (presc_clr),
        .load_i (presc_load),
        .en_i   (presc_en),
        .div_i  (tick_div),
        .tick_o (tick)
    );

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        done_d     = 1'b0;
        presc_clr  = 1'b0;
        presc_load = 1'b0;
        presc_en   = 1'b0;
        duty_nxt   = duty_q;
        if (!ramp_en) begin
            state_d   = IDLE;
            duty_d    = target_duty;
            presc_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (target_duty > duty_q) begin
                        state_d    = UP;
                        presc_load = 1'b1;
                    end else if (target_duty < duty_q) begin
`ifdef PWM_RAMP_DOWN_EN
                        state_d    = DOWN;
                        presc_load = 1'b1;
`else
                        duty_d = target_duty;
                        done_d = 1'b1;
`endif
                    end
                end
                default: begin
                    presc_en = 1'b1;
                    if (tick) begin
                        if (target_duty > duty_q) begin
                            duty_nxt = sat_add(duty_q, step9, target_duty);
`ifdef PWM_RAMP_DOWN_EN
                        end else if (target_duty < duty_q) begin
                            duty_nxt = sat_sub(duty_q, step9, target_duty);
`endif
                        end
                        duty_d = duty_nxt;
                        if (duty_nxt == target_duty) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = (target_duty > duty_q) ? UP : DOWN;
                        end
                    end
`ifndef PWM_RAMP_DOWN_EN
                    // Without a DOWN state a falling target is applied immediately, tick or not.
                    if (target_duty < duty_q) begin
                        state_d   = IDLE;
                        duty_d    = target_duty;
                        done_d    = 1'b1;
                        presc_clr = 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001: Parameter DIV_W, default 8, width of the tick-divider input and prescaler counter.
REQ-002: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: ramp_en  input  1  1 = slew duty toward target; 0 = bypass (duty follows target directly).
REQ-005: target_duty  input  8  requested duty cycle, e.g. from the SPI register bank.
REQ-006: step_size  input  4  duty increment per tick; value 0 is treated as 1.
REQ-007: tick_div  input  DIV_W  ticks occur every tick_div+1 clocks.
REQ-008: duty_out  output  8  registered duty cycle, fed to the PWM peripheral's duty input.
REQ-009: busy  output  1  high while state is UP or DOWN.
REQ-010: done  output  1  one-cycle pulse when a ramp lands on target.

Function
REQ-011: The FSM SHALL have states IDLE, UP and DOWN; busy = (state != IDLE), registered.
REQ-012: ramp_en=0 -> state forced to IDLE; prescaler cleared; duty_out <= target_duty with 1-clock latency; done stays 0.
REQ-013: IDLE with ramp_en=1 -> target > duty_out goes UP; target < duty_out goes DOWN; equal stays IDLE; prescaler loaded with tick_div on entry.
REQ-014: In UP/DOWN the prescaler SHALL decrement each clock; at 0 a tick occurs and the prescaler reloads tick_div.
REQ-015: On tick in UP: duty_out <= min(duty_out + step, target), computed at 9 bits, no wrap past 255.
REQ-016: On tick in DOWN: duty_out <= max(duty_out - step, target), computed at 9 bits, no wrap below 0.
REQ-017: Direction SHALL be re-evaluated against the current target_duty at every tick; crossing the target switches UP<->DOWN without reloading the prescaler early.
REQ-018: When a tick makes duty_out equal target: next state IDLE, and done=1 in the same cycle that duty_out first shows the target value.
REQ-019: tick_div=0 -> a tick occurs every clock.
REQ-020: Target change while IDLE with ramp_en=1 starts a new ramp per REQ-013; no done is issued if no step is taken.
REQ-021: ramp_en falling mid-ramp -> next clock IDLE, busy=0, no done, duty_out=target_duty.

Reset
REQ-022: While rst_n=0, asynchronously: duty_out=0x00, busy=0, done=0, state=IDLE, prescaler=0.
REQ-023: First evaluation after rst_n rises SHALL follow REQ-012/013 from duty_out=0.

Configuration
REQ-024: Macro PWM_RAMP_DOWN_EN defined -> decreases are slewed per REQ-016.
REQ-025: Macro PWM_RAMP_DOWN_EN undefined -> DOWN state is not built.
REQ-026: Without PWM_RAMP_DOWN_EN, any target below duty_out (IDLE or UP) sets duty_out <= target_duty on the next clock, state IDLE, done=1 for that cycle.

Structure
REQ-027: Package pwm_ramp_pkg SHALL hold the state enum (IDLE/UP/DOWN), DUTY_W=8, STEP_W=4.
REQ-028: Sub-module pwm_ramp_tick SHALL implement the reloadable prescaler (load, enable, tick out); the FSM and saturating arithmetic stay in pwm_ramp_ctrl.

Verification
REQ-029: Reset, then ramp_en=1, target=0x10, step=4, tick_div=3 -> duty_out 0,4,8,12,16 on 4-clock ticks; done pulses once at 16; busy then falls.
REQ-030: duty=0xFA, target=0xFF, step=15, tick_div=0 -> next tick duty=0xFF (clamped, no wrap), done=1.
REQ-031: PWM_RAMP_DOWN_EN defined, duty=0x40, target=0x00, step=0, tick_div=0 -> decrements by 1 per clock for 64 clocks, done at 0x00.
REQ-032: Ramping UP to 0x80 at duty=0x30, target changed to 0x20 -> next tick state DOWN, duty steps toward 0x20.
REQ-033: ramp_en=0, target=0x9C -> duty_out=0x9C one clock later, busy=0, done=0; rst_n asserted mid-ramp -> all outputs zero immediately.
REQ-034: PWM_RAMP_DOWN_EN undefined, duty=0x50, target=0x10 -> duty_out=0x10 next clock, done=1 for one cycle.
